// File: rtl/operand_gen_pkg.sv
// rtl/operand_gen_pkg.sv - shared types and the LFSR step function for operand_gen
//
// Contents:
//   state_t     : burst FSM states (ST_IDLE, ST_RUN, ST_DONE)
//   mode_t      : pattern selector (MODE_INCR, MODE_LFSR)
//   LFSR_MAX_W  : widest operand the LFSR helper supports
//   lfsr_step() : one Galois LFSR step on a zero-extended value
package operand_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_INCR = 1'b0,
        MODE_LFSR = 1'b1
    } mode_t;

    localparam int LFSR_MAX_W = 64;

    // Shift right; fold the tap mask back in when the bit shifted out was 1.
    // Callers zero-extend narrower operands, so the upper bits stay zero and
    // the truncated result is exactly the DATA_W-bit step.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] val,
        input logic [LFSR_MAX_W-1:0] poly
    );
        return (val >> 1) ^ (val[0] ? poly : '0);
    endfunction

endpackage

// File: rtl/operand_chan.sv
// rtl/operand_chan.sv - one operand channel: pattern register, transfer counter, valid/ready hold
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : start of a burst; loads the seed selected by load_mode
//   load_mode  : pattern mode presented together with load
//   run_mode   : latched pattern mode used while the burst runs
//   len        : latched burst length (words)
//   ready      : sink ready
//   dout/valid : operand and its valid flag (registered)
//   fin        : registered flag, set once len words have transferred
module operand_chan
    import operand_gen_pkg::*;
#(
    parameter int              DATA_W    = 8,
    parameter int              CNT_W     = 16,
    parameter logic [DATA_W-1:0] POLY    = 8'hB8,
    parameter logic [DATA_W-1:0] INCR_SEED = '0,
    parameter logic [DATA_W-1:0] LFSR_SEED = 1,
    parameter bit              INCR_DOWN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  mode_t             load_mode,
    input  mode_t             run_mode,
    input  logic [CNT_W-1:0]  len,
    input  logic              ready,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              fin
);

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [DATA_W-1:0] word_next;

    assign count_next = count + CNT_W'(1);

    // Channel B counts down so that its word k equals ~k.
    always_comb begin
        word_next = dout;
        if (run_mode == MODE_LFSR)
            word_next = DATA_W'(lfsr_step(LFSR_MAX_W'(dout), LFSR_MAX_W'(POLY)));
        else if (INCR_DOWN)
            word_next = dout - DATA_W'(1);
        else
            word_next = dout + DATA_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout  <= '0;
            valid <= 1'b0;
            count <= '0;
            fin   <= 1'b0;
        end else if (load) begin
            dout  <= (load_mode == MODE_LFSR) ? LFSR_SEED : INCR_SEED;
            valid <= 1'b1;
            count <= '0;
            fin   <= 1'b0;
        end else if (valid && ready) begin
            // Word and valid only move on a transfer, so a stalled word holds.
            dout  <= word_next;
            count <= count_next;
            if (count_next == len) begin
                valid <= 1'b0;
                fin   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_gen.sv
// rtl/operand_gen.sv - two-channel operand burst generator (incrementing or LFSR patterns)
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : burst request, honoured only in IDLE
//   burst_len, mode   : words per channel and pattern, sampled on an accepted start
//   dout_a/valid_a/ready_a : channel A stream
//   dout_b/valid_b/ready_b : channel B stream
//   busy              : burst in progress
//   done              : one-cycle pulse at burst completion
module operand_gen
    import operand_gen_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                CNT_W  = 16,
    parameter logic [DATA_W-1:0] POLY   = 8'hB8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              mode,
    output logic [DATA_W-1:0] dout_a,
    output logic              valid_a,
    input  logic              ready_a,
    output logic [DATA_W-1:0] dout_b,
    output logic              valid_b,
    input  logic              ready_b,
    output logic              busy,
    output logic              done
);

    state_t           state;
    logic [CNT_W-1:0] cfg_len;
    mode_t            cfg_mode;
    logic             load;
    logic             fin_a;
    logic             fin_b;

    // Channels load on the same edge that the FSM enters RUN, so valid
    // appears in the cycle right after the accepted start.
    assign load = (state == ST_IDLE) && start && (burst_len != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cfg_len  <= '0;
            cfg_mode <= MODE_INCR;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (burst_len != '0) begin
                            cfg_len  <= burst_len;
                            cfg_mode <= mode_t'(mode);
                            busy     <= 1'b1;
                            state    <= ST_RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (fin_a && fin_b) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    operand_chan #(
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .POLY      (POLY),
        .INCR_SEED ('0),
        .LFSR_SEED (DATA_W'(1)),
        .INCR_DOWN (1'b0)
    ) u_chan_a (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_mode (mode_t'(mode)),
        .run_mode  (cfg_mode),
        .len       (cfg_len),
        .ready     (ready_a),
        .dout      (dout_a),
        .valid     (valid_a),
        .fin       (fin_a)
    );

    operand_chan #(
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .POLY      (POLY),
        .INCR_SEED ('1),
        .LFSR_SEED ('1),
        .INCR_DOWN (1'b1)
    ) u_chan_b (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_mode (mode_t'(mode)),
        .run_mode  (cfg_mode),
        .len       (cfg_len),
        .ready     (ready_b),
        .dout      (dout_b),
        .valid     (valid_b),
        .fin       (fin_b)
    );

endmodule
